// File: rtl/fetch_decode_elastic_reg.sv
// Fetch2->Decode elastic pipeline register: main + skid entry, flop-driven ready,
// plus a one-cycle delayed branch-update bundle and a saturating stall counter.
module fetch_decode_elastic_reg #(
  parameter int FETCH_WIDTH = 4,
  parameter int PKT_W       = 97,
  parameter int UPD_W       = 99,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic [FETCH_WIDTH-1:0]       in_valid_i,
  input  logic [FETCH_WIDTH*PKT_W-1:0] in_pkt_i,
  output logic                         in_ready_o,
  output logic [FETCH_WIDTH-1:0]       out_valid_o,
  output logic [FETCH_WIDTH*PKT_W-1:0] out_pkt_o,
  input  logic                         out_ready_i,
  input  logic [UPD_W-1:0]             upd_i,
  input  logic                         upd_en_i,
  output logic [UPD_W-1:0]             upd_o,
  output logic                         upd_en_o,
  output logic [CNT_W-1:0]             stall_cycles_o
);

  localparam int BW = FETCH_WIDTH * PKT_W;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                 state, state_nxt;
  logic [FETCH_WIDTH-1:0] main_mask, main_mask_nxt, skid_mask, skid_mask_nxt;
  logic [BW-1:0]          main_pkt, main_pkt_nxt, skid_pkt, skid_pkt_nxt;
  logic                   ready_r;
  logic                   main_v;
  logic                   acc;
  logic                   con;
  logic [CNT_W-1:0]       stall_cnt;
  logic [UPD_W-1:0]       upd_p1;
  logic                   upd_en_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign main_v = (state != EMPTY);
  assign acc    = (|in_valid_i) & ready_r;
  assign con    = main_v & out_ready_i;

  always_comb begin
    state_nxt     = state;
    main_mask_nxt = main_mask;
    main_pkt_nxt  = main_pkt;
    skid_mask_nxt = skid_mask;
    skid_pkt_nxt  = skid_pkt;
    case (state)
      EMPTY: begin
        if (acc) begin
          main_mask_nxt = in_valid_i;
          main_pkt_nxt  = in_pkt_i;
          state_nxt     = ONE;
        end
      end
      ONE: begin
        if (acc && con) begin
          main_mask_nxt = in_valid_i;
          main_pkt_nxt  = in_pkt_i;
        end else if (acc) begin
          skid_mask_nxt = in_valid_i;
          skid_pkt_nxt  = in_pkt_i;
          state_nxt     = TWO;
        end else if (con) begin
          main_mask_nxt = '0;
          main_pkt_nxt  = '0;
          state_nxt     = EMPTY;
        end
      end
      TWO: begin
        if (con) begin
          main_mask_nxt = skid_mask;
          main_pkt_nxt  = skid_pkt;
          skid_mask_nxt = '0;
          skid_pkt_nxt  = '0;
          state_nxt     = ONE;
        end
      end
      default: begin
        main_mask_nxt = '0;
        main_pkt_nxt  = '0;
        skid_mask_nxt = '0;
        skid_pkt_nxt  = '0;
        state_nxt     = EMPTY;
      end
    endcase
    // Flush discards both entries, including anything offered this cycle.
    if (flush_i) begin
      main_mask_nxt = '0;
      main_pkt_nxt  = '0;
      skid_mask_nxt = '0;
      skid_pkt_nxt  = '0;
      state_nxt     = EMPTY;
    end
  end

  // Buffer stage: ready is registered from the next state so Decode stalls never reach Fetch2.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      ready_r   <= 1'b1;
      main_mask <= '0;
      main_pkt  <= '0;
      skid_mask <= '0;
      skid_pkt  <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ready_r   <= (state_nxt != TWO);
      main_mask <= main_mask_nxt;
      main_pkt  <= main_pkt_nxt;
      skid_mask <= skid_mask_nxt;
      skid_pkt  <= skid_pkt_nxt;
      if (main_v && !out_ready_i) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Update stage: straight one-cycle delay, blind to flush and back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_p1    <= '0;
      upd_en_p1 <= 1'b0;
    end else begin
      upd_p1    <= upd_i;
      upd_en_p1 <= upd_en_i;
    end
  end

  assign in_ready_o     = ready_r;
  assign out_valid_o    = main_v ? main_mask : '0;
  assign out_pkt_o      = main_pkt;
  assign upd_o          = upd_p1;
  assign upd_en_o       = upd_en_p1;
  assign stall_cycles_o = stall_cnt;

endmodule

// File: tb/tb_fetch_decode_elastic_reg.sv
// Scoreboard bench for fetch_decode_elastic_reg: directed bundles, expected queue,
// negedge monitor popping on every consume.
module tb_fetch_decode_elastic_reg;

  localparam int FW    = 4;
  localparam int PKT_W = 97;
  localparam int UPD_W = 99;
  localparam int CNT_W = 16;
  localparam int BW    = FW * PKT_W;

  typedef struct packed {
    logic [FW-1:0] mask;
    logic [BW-1:0] pkt;
  } bundle_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush_i;
  logic [FW-1:0]    in_valid_i;
  logic [BW-1:0]    in_pkt_i;
  logic             in_ready_o;
  logic [FW-1:0]    out_valid_o;
  logic [BW-1:0]    out_pkt_o;
  logic             out_ready_i;
  logic [UPD_W-1:0] upd_i;
  logic             upd_en_i;
  logic [UPD_W-1:0] upd_o;
  logic             upd_en_o;
  logic [CNT_W-1:0] stall_cycles_o;

  bundle_t exp_q[$];
  int checks = 0;
  int errors = 0;

  fetch_decode_elastic_reg #(
    .FETCH_WIDTH(FW), .PKT_W(PKT_W), .UPD_W(UPD_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_pkt_i(in_pkt_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_pkt_o(out_pkt_o), .out_ready_i(out_ready_i),
    .upd_i(upd_i), .upd_en_i(upd_en_i), .upd_o(upd_o), .upd_en_o(upd_en_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] mk_pkt(input int seed);
    logic [BW-1:0]    p;
    logic [PKT_W-1:0] lane;
    p = '0;
    for (int k = 0; k < FW; k++) begin
      lane = {1'b1, 32'(seed), 32'hA5A5_0000 + 32'(k), 32'(seed * 3 + k)};
      p[k*PKT_W +: PKT_W] = lane;
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [FW-1:0] mask, input int seed, input bit will_accept);
    bundle_t b;
    in_valid_i = mask;
    in_pkt_i   = mk_pkt(seed);
    if (will_accept) begin
      b.mask = mask;
      b.pkt  = in_pkt_i;
      exp_q.push_back(b);
    end
  endtask

  task automatic idle();
    in_valid_i = '0;
    in_pkt_i   = '0;
  endtask

  // Monitor: every consume handshake must deliver the oldest outstanding bundle.
  always @(negedge clk) begin
    bundle_t e;
    if (!reset && (|out_valid_o) && out_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got mask %0h pkt %0h, expected no bundle", out_valid_o, out_pkt_o);
      end else begin
        e = exp_q.pop_front();
        if (out_valid_o !== e.mask || out_pkt_o !== e.pkt) begin
          errors++;
          $display("FAIL out_bundle: got mask %0h pkt %0h expected mask %0h pkt %0h",
                   out_valid_o, out_pkt_o, e.mask, e.pkt);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    upd_i = '0; upd_en_i = 1'b0;
    idle();
    repeat (2) cyc();
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_pkt", out_pkt_o, 0);
    check("rst_stall", stall_cycles_o, 0);
    check("rst_upd_en", upd_en_o, 0);
    reset = 1'b0;

    // Streaming
    offer(4'b1111, 1, 1); cyc();
    check("stream_valid_a", out_valid_o, 4'b1111);
    check("stream_ready_a", in_ready_o, 1);
    offer(4'b0011, 2, 1); cyc();
    check("stream_valid_b", out_valid_o, 4'b0011);
    check("stream_ready_b", in_ready_o, 1);
    idle(); cyc();
    check("stream_drain", out_valid_o, 0);
    check("stream_stall", stall_cycles_o, 0);

    // Empty mask with live packet data is ignored
    in_valid_i = '0; in_pkt_i = mk_pkt(9); cyc(); cyc();
    check("empty_valid", out_valid_o, 0);
    check("empty_pkt", out_pkt_o, 0);
    check("empty_ready", in_ready_o, 1);

    // Back-pressure: A to main, B to skid, C refused
    out_ready_i = 1'b0;
    offer(4'b1111, 3, 1); cyc();
    check("bp_ready_one", in_ready_o, 1);
    offer(4'b0101, 4, 1); cyc();
    check("bp_ready_two", in_ready_o, 0);
    offer(4'b1111, 5, 0); upd_i = 99'h1234; upd_en_i = 1'b1; cyc();
    check("bp_ready_hold", in_ready_o, 0);
    check("upd_en_stall", upd_en_o, 1);
    check("upd_stall", upd_o, 99'h1234);
    upd_en_i = 1'b0; upd_i = '0; cyc();
    check("bp_stall3", stall_cycles_o, 3);
    check("bp_head", out_valid_o, 4'b1111);
    check("upd_en_drop", upd_en_o, 0);
    idle(); out_ready_i = 1'b1; cyc();
    check("bp_second", out_valid_o, 4'b0101);
    check("bp_ready_back", in_ready_o, 1);
    cyc();
    check("bp_empty", out_valid_o, 0);
    check("bp_stall_keep", stall_cycles_o, 3);

    // Flush in TWO with a bundle offered and an update pulse
    out_ready_i = 1'b0;
    offer(4'b1111, 6, 1); cyc();
    offer(4'b0110, 7, 1); cyc();
    check("fl_two", in_ready_o, 0);
    offer(4'b1111, 8, 0); flush_i = 1'b1; upd_i = 99'h1234; upd_en_i = 1'b1;
    cyc();
    exp_q.delete();
    flush_i = 1'b0; upd_en_i = 1'b0; upd_i = '0; idle();
    check("fl_valid", out_valid_o, 0);
    check("fl_pkt", out_pkt_o, 0);
    check("fl_ready", in_ready_o, 1);
    check("fl_stall", stall_cycles_o, 5);
    check("fl_upd_en", upd_en_o, 1);
    check("fl_upd", upd_o, 99'h1234);
    out_ready_i = 1'b1; cyc(); cyc();
    check("fl_gone", out_valid_o, 0);

    // Flush coinciding with a consume: head is delivered, offered bundle dropped
    offer(4'b1001, 10, 1); cyc();
    offer(4'b1111, 11, 0); flush_i = 1'b1; cyc();
    exp_q.delete();
    flush_i = 1'b0; idle();
    check("flc_valid", out_valid_o, 0);
    check("flc_ready", in_ready_o, 1);
    cyc();
    check("flc_gone", out_valid_o, 0);

    // Reset while in TWO
    out_ready_i = 1'b0;
    offer(4'b1111, 12, 1); cyc();
    offer(4'b1100, 13, 1); cyc();
    check("rs_two", in_ready_o, 0);
    idle(); reset = 1'b1; upd_i = 99'h55; upd_en_i = 1'b1; cyc();
    exp_q.delete();
    check("rs_valid", out_valid_o, 0);
    check("rs_pkt", out_pkt_o, 0);
    check("rs_ready", in_ready_o, 1);
    check("rs_stall", stall_cycles_o, 0);
    check("rs_upd_en", upd_en_o, 0);
    check("rs_upd", upd_o, 0);
    reset = 1'b0; upd_en_i = 1'b0; upd_i = '0; out_ready_i = 1'b1;
    cyc(); cyc();
    check("rs_quiet", out_valid_o, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
